// File: rtl/lcd_cmd_dispatcher.sv
// lcd_cmd_dispatcher
// Buffers host opcodes in a small FIFO and drops illegal ones. It feeds LCD_CTRL
// one command per idle window and follows LCD_CTRL's busy handshake. After the
// Write opcode (0) is issued, the block locks. When LCD_CTRL reports done, it
// latches dispatch_done.
//
// Handshake summary:
// - Host side: a word transfers on a rising edge where host_valid && host_ready.
//   host_ready does not depend on host_valid.
//   An opcode above MAX_OP still completes the handshake, but it is discarded
//   and illegal_err is set.
// - LCD side: cmd_valid is a one-cycle strobe. It is raised only from an idle
//   window that was entered with busy low.
//   cmd holds the last issued opcode between strobes.
module lcd_cmd_dispatcher #(
    parameter int DEPTH  = 8,
    parameter int GUARD  = 2,
    parameter int MAX_OP = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               host_cmd,
    input  logic                     host_valid,
    output logic                     host_ready,
    output logic [3:0]               cmd,
    output logic                     cmd_valid,
    input  logic                     busy,
    input  logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [7:0]               issued_cnt,
    output logic                     illegal_err,
    output logic                     dispatch_done,
    output logic [2:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = (GUARD < 2) ? 1 : $clog2(GUARD + 1);

    localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);
    localparam logic [AW:0]   DEPTH_L    = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [4:0]    MAX_OP_L   = 5'(MAX_OP);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_WAIT_FALL = 3'd3,
        S_LOCKED    = 3'd4,
        S_FINISHED  = 3'd5
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [GW-1:0]   guard_cnt;
    logic [GW-1:0]   guard_n;

    logic [3:0]      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level;

    logic            fifo_full;
    logic            fifo_empty;
    logic            accepting;
    logic            handshake;
    logic            op_illegal;
    logic            push;
    logic            pop;
    logic            load_cmd;

    assign fifo_full  = (level == DEPTH_L);
    assign fifo_empty = (level == '0);
    assign accepting  = (state != S_LOCKED) && (state != S_FINISHED);

    // host_ready is gated by reset, so it reads 0 while reset is held.
    assign host_ready = reset && !fifo_full && accepting;
    assign handshake  = host_valid && host_ready;
    assign op_illegal = ({1'b0, host_cmd} > MAX_OP_L);
    assign push       = handshake && !op_illegal;
    assign pop        = (state == S_ISSUE);

    assign cmd_valid  = (state == S_ISSUE);
    assign fifo_level = level;
    assign state_dbg  = state;

    // FIFO storage; slots are only read after being written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= host_cmd;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_ONE;
                2'b01:   level <= level - LEVEL_ONE;
                default: level <= level;
            endcase
        end
    end

    // FSM state and guard counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            guard_cnt <= '0;
        end else begin
            state     <= state_n;
            guard_cnt <= guard_n;
        end
    end

    // Next-state logic: one issue per LCD_CTRL idle window
    always_comb begin
        state_n  = state;
        guard_n  = guard_cnt;
        load_cmd = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && !busy) begin
                    state_n  = S_ISSUE;
                    load_cmd = 1'b1;
                end
            end
            S_ISSUE: begin
                if (cmd == 4'd0) begin
                    state_n = S_LOCKED;
                end else begin
                    state_n = S_WAIT_RISE;
                    guard_n = GUARD_INIT;
                end
            end
            S_WAIT_RISE: begin
                // If busy never rises within the guard window, treat the command as single-cycle.
                if (busy) begin
                    state_n = S_WAIT_FALL;
                end else if (guard_cnt <= GUARD_ONE) begin
                    state_n = S_IDLE;
                    guard_n = '0;
                end else begin
                    guard_n = guard_cnt - GUARD_ONE;
                end
            end
            S_WAIT_FALL: begin
                if (!busy) begin
                    state_n = S_IDLE;
                end
            end
            S_LOCKED: begin
                if (done) begin
                    state_n = S_FINISHED;
                end
            end
            S_FINISHED: begin
                state_n = S_FINISHED;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // cmd captures the FIFO head when entering ISSUE and holds it afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd <= 4'd0;
        end else if (load_cmd) begin
            cmd <= mem[rd_ptr];
        end
    end

    // Saturating count of issued commands
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issued_cnt <= 8'd0;
        end else if (pop && (issued_cnt != 8'hFF)) begin
            issued_cnt <= issued_cnt + 8'd1;
        end
    end

    // Sticky flags: illegal opcode offered and Write completion observed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_err   <= 1'b0;
            dispatch_done <= 1'b0;
        end else begin
            if (handshake && op_illegal) begin
                illegal_err <= 1'b1;
            end
            if ((state == S_LOCKED) && done) begin
                dispatch_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lcd_cmd_dispatcher.sv
// Directed bench for lcd_cmd_dispatcher with a small LCD_CTRL busy model.
`timescale 1ns/1ps
module tb_lcd_cmd_dispatcher;

    localparam int DEPTH  = 8;
    localparam int GUARD  = 2;
    localparam int MAX_OP = 11;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOCKED   = 3'd4;
    localparam logic [2:0] ST_FINISHED = 3'd5;

    // clock / reset and DUT signals
    logic        clk        = 1'b0;
    logic        reset      = 1'b0;
    logic [3:0]  host_cmd   = 4'd0;
    logic        host_valid = 1'b0;
    logic        busy       = 1'b1;
    logic        done       = 1'b0;
    logic        host_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic [3:0]  fifo_level;
    logic [7:0]  issued_cnt;
    logic        illegal_err;
    logic        dispatch_done;
    logic [2:0]  state_dbg;

    // bookkeeping
    int          vec_cnt     = 0;
    int          err_cnt     = 0;
    int          cycle       = 0;
    int          seen_issues = 0;
    int          last_issue  = -1;
    int          issue_cyc[$];
    logic [3:0]  exp_q[$];

    // LCD_CTRL model controls: 0 = busy follows manual_busy only,
    // 1 = busy held 3 cycles after each issue, 2 = never busy (single-cycle)
    int          model_mode  = 0;
    logic        manual_busy = 1'b1;
    int          busy_cnt    = 0;
    logic        pend        = 1'b0;

    lcd_cmd_dispatcher #(
        .DEPTH  (DEPTH),
        .GUARD  (GUARD),
        .MAX_OP (MAX_OP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host_cmd      (host_cmd),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .cmd           (cmd),
        .cmd_valid     (cmd_valid),
        .busy          (busy),
        .done          (done),
        .fifo_level    (fifo_level),
        .issued_cnt    (issued_cnt),
        .illegal_err   (illegal_err),
        .dispatch_done (dispatch_done),
        .state_dbg     (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard on issue strobes, plus the LCD_CTRL busy model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmd_valid === 1'b1) begin
                check("busy_at_issue", busy, 0);
                if (last_issue >= 0) begin
                    check("issue_spacing_ge2", 32'((cycle - last_issue) >= 2), 1);
                end
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", exp_q.size(), 1);
                end else begin
                    check("issue_order", cmd, exp_q.pop_front());
                end
                last_issue = cycle;
                issue_cyc.push_back(cycle);
                seen_issues++;
                if (model_mode == 1) pend = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pend) begin
                busy_cnt = 3;
                pend     = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            busy = manual_busy || (busy_cnt != 0);
        end
    end

    // driver tasks; all assume entry at posedge+1
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op);
        int n = 0;
        host_cmd   = op;
        host_valid = 1'b1;
        @(negedge clk);
        while (host_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (host_ready !== 1'b1) check("push_ready", host_ready, 1);
        @(posedge clk);
        #1;
        host_valid = 1'b0;
    endtask

    task automatic push_try(input logic [3:0] op);
        host_cmd   = op;
        host_valid = 1'b1;
        tick(1);
        host_valid = 1'b0;
    endtask

    task automatic wait_issues(input int target);
        int n = 0;
        while (seen_issues < target && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("issue_count", seen_issues, target);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;
        // reset values, busy high out of reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd", cmd, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_host_ready", host_ready, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_issued_cnt", issued_cnt, 0);
        check("rst_illegal_err", illegal_err, 0);
        check("rst_dispatch_done", dispatch_done, 0);
        check("rst_state", state_dbg, ST_IDLE);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // preload {1,2,3} with busy held high
        push(4'd1);
        push(4'd2);
        push(4'd3);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        tick(60);
        check("p1_level_busy", fifo_level, 3);
        check("p1_no_issue", seen_issues, 0);
        check("p1_done_ignored", dispatch_done, 0);
        check("p1_ready", host_ready, 1);
        exp_q.push_back(4'd1);
        exp_q.push_back(4'd2);
        exp_q.push_back(4'd3);
        model_mode  = 1;
        manual_busy = 1'b0;
        wait_issues(1);
        check("p1_first_cnt", issued_cnt, 1);
        check("p1_first_cmd", cmd, 1);
        wait_issues(3);
        tick(8);
        check("p1_cnt", issued_cnt, 3);
        check("p1_level_empty", fifo_level, 0);
        check("p1_idle", state_dbg, ST_IDLE);

        // 5,6,7,0 through a 3-cycle busy model; 8 stays behind the Write
        exp_q.push_back(4'd5);
        exp_q.push_back(4'd6);
        exp_q.push_back(4'd7);
        exp_q.push_back(4'd0);
        push(4'd5);
        push(4'd6);
        push(4'd7);
        push(4'd0);
        push(4'd8);
        wait_issues(7);
        tick(2);
        check("p2_locked", state_dbg, ST_LOCKED);
        check("p2_ready_locked", host_ready, 0);
        check("p2_cnt", issued_cnt, 7);
        check("p2_cmd_hold", cmd, 0);
        check("p2_level_held", fifo_level, 1);
        push_try(4'd9);
        tick(1);
        check("p2_level_no_push", fifo_level, 1);
        check("p2_no_issue_locked", seen_issues, 7);
        check("p2_not_done_yet", dispatch_done, 0);
        done = 1'b1;
        tick(1);
        done = 1'b0;
        check("p2_dispatch_done", dispatch_done, 1);
        check("p2_finished", state_dbg, ST_FINISHED);
        tick(5);
        check("p2_still_finished", state_dbg, ST_FINISHED);
        check("p2_cmd_valid_low", cmd_valid, 0);
        check("p2_ready_finished", host_ready, 0);
        check("p2_no_more_issue", seen_issues, 7);
        reset = 1'b0;
        #1;
        check("p2_rst_done", dispatch_done, 0);
        check("p2_rst_level", fifo_level, 0);
        check("p2_rst_cnt", issued_cnt, 0);
        check("p2_rst_state", state_dbg, ST_IDLE);
        check("p2_rst_cmd", cmd, 0);
        check("p2_rst_ready", host_ready, 0);
        manual_busy = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(2);

        // fill beyond depth while busy
        for (int i = 1; i <= DEPTH; i++) begin
            push(4'(i));
            exp_q.push_back(4'(i));
        end
        check("p3_level_full", fifo_level, DEPTH);
        check("p3_ready_full", host_ready, 0);
        push_try(4'd9);
        push_try(4'd10);
        check("p3_level_after_extra", fifo_level, DEPTH);
        manual_busy = 1'b0;
        wait_issues(15);
        tick(8);
        check("p3_cnt", issued_cnt, DEPTH);
        check("p3_level_empty", fifo_level, 0);

        // illegal opcodes between legal ones
        manual_busy = 1'b1;
        tick(2);
        check("p4_illegal_clear", illegal_err, 0);
        push(4'd3);
        push(4'd12);
        check("p4_illegal_set", illegal_err, 1);
        check("p4_level_after_12", fifo_level, 1);
        push(4'd15);
        push(4'd4);
        check("p4_level", fifo_level, 2);
        exp_q.push_back(4'd3);
        exp_q.push_back(4'd4);
        manual_busy = 1'b0;
        wait_issues(17);
        tick(8);
        check("p4_cnt", issued_cnt, 10);
        check("p4_illegal_sticky", illegal_err, 1);
        check("p4_level_empty", fifo_level, 0);

        // single-cycle commands: busy never rises
        model_mode  = 2;
        manual_busy = 1'b1;
        tick(2);
        push(4'd9);
        push(4'd10);
        push(4'd11);
        exp_q.push_back(4'd9);
        exp_q.push_back(4'd10);
        exp_q.push_back(4'd11);
        manual_busy = 1'b0;
        wait_issues(20);
        tick(4);
        if (issue_cyc.size() == 20) begin
            d = issue_cyc[18] - issue_cyc[17];
            check("p5_gap_a", d, GUARD + 2);
            d = issue_cyc[19] - issue_cyc[18];
            check("p5_gap_b", d, GUARD + 2);
        end else begin
            check("p5_issue_log", issue_cyc.size(), 20);
        end
        check("p5_cnt", issued_cnt, 13);

        // reset while cmd_valid is high
        manual_busy = 1'b1;
        tick(2);
        push(4'd5);
        push(4'd6);
        exp_q.push_back(4'd5);
        manual_busy = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (cmd_valid !== 1'b1 && n < 100);
        check("p6_saw_issue", cmd_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("p6_rst_cmd_valid", cmd_valid, 0);
        check("p6_rst_cmd", cmd, 0);
        check("p6_rst_level", fifo_level, 0);
        check("p6_rst_cnt", issued_cnt, 0);
        check("p6_rst_illegal", illegal_err, 0);
        check("p6_rst_ready", host_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(10);
        check("p6_no_issue_after_rst", seen_issues, 21);
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_dispatcher.md
Name: lcd_cmd_dispatcher

Overview:
- Sits directly upstream of LCD_CTRL and drives its cmd/cmd_valid pair from a host-side command FIFO, obeying LCD_CTRL's busy handshake.
- Buffers host commands and filters illegal opcodes.
- Issues exactly one command per LCD_CTRL idle window.
- Stops after the Write (opcode 0) command and then reports completion once LCD_CTRL asserts done.

Parameters:
- DEPTH, 8, command FIFO depth in entries (power of two, ≥2).
- GUARD, 2, cycles allowed after issue for busy to rise before the command is treated as single-cycle.
- MAX_OP, 11, highest legal opcode; opcodes above this are dropped.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- host_cmd  input  4  command opcode from host.
- host_valid  input  1  host_cmd is valid this cycle.
- host_ready  output  1  FIFO can accept this cycle.
- cmd  output  4  opcode to LCD_CTRL.
- cmd_valid  output  1  one-cycle issue strobe to LCD_CTRL.
- busy  input  1  LCD_CTRL busy.
- done  input  1  LCD_CTRL done pulse/level.
- fifo_level  output  log2(DEPTH)+1  current FIFO occupancy.
- issued_cnt  output  8  commands issued since reset; saturates at 255.
- illegal_err  output  1  sticky: an opcode above MAX_OP was offered and dropped.
- dispatch_done  output  1  sticky: Write issued and done observed.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO empty; state IDLE.
  - cmd=0, cmd_valid=0, host_ready=0, fifo_level=0, issued_cnt=0, illegal_err=0, dispatch_done=0.
- host_ready = (fifo not full) && (state != LOCKED && state != FINISHED), registered-free, derived combinationally from state/level.
- Enqueue:
  - Occurs on a rising edge with host_valid && host_ready.
  - If host_cmd > MAX_OP: not stored, illegal_err set; this still counts as a consumed handshake.
- Simultaneous enqueue and dequeue in one cycle: level unchanged; data order preserved (FIFO, wrap-around pointers).
- Full: host_ready=0; host_valid is ignored and nothing is overwritten.
- Empty: no issue.
- State machine (one state per cycle):
  - IDLE: if FIFO non-empty and busy=0 -> ISSUE.
  - ISSUE: cmd=head, cmd_valid=1 for exactly this cycle; pop head; issued_cnt+1.
    - If opcode=0 -> LOCKED.
    - Otherwise -> WAIT_RISE with guard counter = GUARD.
  - WAIT_RISE: if busy=1 -> WAIT_FALL; else decrement guard; at 0 -> IDLE.
  - WAIT_FALL: when busy=0 -> IDLE.
  - LOCKED: FIFO contents remaining are held, not issued; when done=1 -> FINISHED, dispatch_done=1.
  - FINISHED: terminal until reset; cmd_valid stays 0.
- cmd holds last issued opcode between issues; cmd_valid never asserted while busy=1 at the issuing edge.
- Minimum spacing between two issues is 2 cycles (ISSUE, then at least one WAIT/IDLE cycle).
- done seen outside LOCKED is ignored.
- busy high out of reset (LCD_CTRL image load): the dispatcher stays in IDLE and does not issue until busy=0.
- Reset mid-operation: all state cleared immediately, including sticky flags; any pending cmd_valid drops asynchronously.

Test Plan:
- Reset with busy=1 for 70 cycles, FIFO preloaded with {1,2,3} -> no cmd_valid until busy falls; then cmd=1 issued, issued_cnt=1.
- LCD_CTRL model holds busy 3 cycles per command; host pushes 5,6,7,0 -> cmd_valid pulses carry 5,6,7,0 in order, each separated by busy window; state ends LOCKED, host_ready=0.
- Push DEPTH+2 commands with busy=1 -> fifo_level=DEPTH, host_ready=0, extra two are not stored; after release, exactly DEPTH commands are issued in order.
- Push opcodes 12 and 15 between 3 and 4 -> illegal_err=1, only 3,4 issued, fifo_level never counts 12/15.
- Model that never raises busy (single-cycle command) with GUARD=2 -> next command issued 4 cycles after previous ISSUE (ISSUE, 2 guard, IDLE).
- Issue 0, pulse done 5 cycles later -> dispatch_done=1; assert reset=0 mid-sequence -> all outputs back to reset values the same cycle.
